// File: rtl/bcd_display_scan_if.sv
// Display-scan bus: packed BCD/dp capture inputs and multiplexed segment outputs.
// Latency: none, this is a wiring bundle only.
// Backpressure: none; load is level-sampled and the display is free-running.
interface bcd_display_scan_if;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  ssd_ctl;
  logic [7:0]  ssd_seg;
  logic        frame_done;

  // Producer side: supplies digits, observes the display lines.
  modport master (
    output bcd_in, dp_in, load, blank_lz,
    input  ssd_ctl, ssd_seg, frame_done
  );

  // Display driver side.
  modport slave (
    input  bcd_in, dp_in, load, blank_lz,
    output ssd_ctl, ssd_seg, frame_done
  );
endinterface

// File: rtl/bcd_display_scan.sv
// 4-digit common-anode seven-segment scanner with frame-aligned double buffering.
// Latency: load to display 1 clk (load on the wrap edge) up to 4*SCAN_DIV clks.
// Backpressure: none; newest pending load wins, shadow updates only at frame wrap.
module bcd_display_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_display_scan_if.slave   bus
);

  logic [15:0] div_cnt;
  logic [1:0]  slot;
  logic        tick;
  logic        wrap;

  logic [15:0] pend_bcd;
  logic [3:0]  pend_dp;
  logic        pend_valid;
  logic [15:0] shad_bcd;
  logic [3:0]  shad_dp;
  logic        frame_done_q;

  logic [3:0]  digit;
  logic [6:0]  seg7;
  logic [3:0]  lz;
  logic [3:0]  ctl_d;
  logic [7:0]  seg_d;

  assign tick = (div_cnt == 16'(SCAN_DIV - 1));
  assign wrap = tick && (slot == 2'd3);

  // Prescaler and slot counter; slot steps once per SCAN_DIV clks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      slot    <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      slot    <= slot + 2'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Double buffer: loads park in pending, shadow only changes at the frame wrap
  // so a count update never tears the frame being scanned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_bcd     <= '0;
      pend_dp      <= '0;
      pend_valid   <= 1'b0;
      shad_bcd     <= '0;
      shad_dp      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= wrap;
      if (wrap) begin
        if (bus.load) begin
          shad_bcd <= bus.bcd_in;
          shad_dp  <= bus.dp_in;
        end else if (pend_valid) begin
          shad_bcd <= pend_bcd;
          shad_dp  <= pend_dp;
        end
        pend_valid <= 1'b0;
      end else if (bus.load) begin
        pend_bcd   <= bus.bcd_in;
        pend_dp    <= bus.dp_in;
        pend_valid <= 1'b1;
      end
    end
  end

  // Segment decode of the selected shadow digit; driven only from registered
  // state plus the live blanking enable.
  always_comb begin
    digit = shad_bcd[{slot, 2'b00} +: 4];
    seg7  = 7'h3F;
    case (digit)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h3F;
    endcase

    // A digit is a leading zero if it and every higher digit are zero; digit0 always shows.
    lz    = '0;
    lz[3] = (shad_bcd[15:12] == 4'd0);
    lz[2] = lz[3] && (shad_bcd[11:8] == 4'd0);
    lz[1] = lz[2] && (shad_bcd[7:4] == 4'd0);

    ctl_d = ~(4'b0001 << slot);
    seg_d = {~shad_dp[slot], seg7};
    if (bus.blank_lz && lz[slot]) begin
      seg_d = 8'hFF;
    end
  end

  assign bus.ssd_ctl    = ctl_d;
  assign bus.ssd_seg    = seg_d;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with SCAN_DIV=4 and an expected-display queue.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// Each frame check walks all 16 clks of a frame, including frame_done.
module tb_bcd_display_scan;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_display_scan_if bus();

  bcd_display_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] sb_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed {fd,ctl,seg}=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_slot(input logic [3:0] ctl, input logic [7:0] seg);
    sb_q.push_back({ctl, seg});
  endtask

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    push_slot(4'b1110, s0);
    push_slot(4'b1101, s1);
    push_slot(4'b1011, s2);
    push_slot(4'b0111, s3);
  endtask

  task automatic check_now(input string tag, input logic fd_exp);
    logic [11:0] e;
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      compare(tag, {bus.frame_done, bus.ssd_ctl, bus.ssd_seg}, {fd_exp, e});
    end
  endtask

  // Called at the first cycle of a frame; checks all 16 cycles and ends at the next frame start.
  task automatic check_frame(input string tag);
    logic [11:0] e;
    if (sb_q.size() < 4) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed %0d queued slots expected 4", tag, sb_q.size());
      sb_q.delete();
    end else begin
      for (int s = 0; s < 4; s++) begin
        e = sb_q.pop_front();
        for (int c = 0; c < SCAN_DIV; c++) begin
          compare(tag, {bus.frame_done, bus.ssd_ctl, bus.ssd_seg},
                  {(s == 0 && c == 0), e});
          step();
        end
      end
    end
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.frame_done !== 1'b1 && n < 64);
    compare(tag, {12'd0, bus.frame_done}, 13'd1);
  endtask

  task automatic load_val(input logic [15:0] bcd, input logic [3:0] dp);
    bus.bcd_in = bcd;
    bus.dp_in  = dp;
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
  endtask

  initial begin
    bus.bcd_in   = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;

    // Reset state
    #2;
    push_slot(4'b1110, 8'hC0);
    check_now("reset_state", 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    step();

    // Scan order: 4321 loaded in slot 1, displayed from the next frame on
    load_val(16'h4321, 4'b0000);
    wait_frame("scan_wait");
    push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
    check_frame("scan_frame1");
    push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
    check_frame("scan_frame2");

    // Mid-frame asynchronous reset with a pending value that must be discarded
    for (int i = 0; i < 5; i++) step();
    load_val(16'h1111, 4'b1111);
    rst_n = 1'b0;
    #1;
    push_slot(4'b1110, 8'hC0);
    check_now("async_reset", 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    push_slot(4'b1110, 8'hC0);
    check_now("release_slot0_hold", 1'b0);
    step();
    push_slot(4'b1101, 8'hC0);
    check_now("release_slot1_at_4clk", 1'b0);
    wait_frame("reset_wait");
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    check_frame("reset_discard_pending");

    // Tearing protection: 1234 then 5678 within one frame, old 0000 holds until the wrap
    for (int i = 0; i < 4; i++) step();
    load_val(16'h1234, 4'b0000);
    push_slot(4'b1101, 8'hC0);
    check_now("tear_slot1_old", 1'b0);
    step();
    step();
    step();
    load_val(16'h5678, 4'b0000);
    push_slot(4'b1011, 8'hC0);
    check_now("tear_slot2_old", 1'b0);
    for (int i = 0; i < 4; i++) step();
    push_slot(4'b0111, 8'hC0);
    check_now("tear_slot3_old", 1'b0);
    wait_frame("tear_wait");
    push_frame(8'h80, 8'hF8, 8'h82, 8'h92);
    check_frame("tear_newest");

    // Coincident load at the wrap edge overrides the pending 0005
    for (int i = 0; i < 4; i++) step();
    load_val(16'h0005, 4'b0000);
    for (int i = 0; i < 10; i++) step();
    load_val(16'h0009, 4'b0000);
    push_frame(8'h90, 8'hC0, 8'hC0, 8'hC0);
    check_frame("coincident_load");

    // Leading-zero blanking with a dp on digit1
    bus.blank_lz = 1'b1;
    load_val(16'h0050, 4'b0010);
    wait_frame("blank_wait");
    push_frame(8'hC0, 8'h12, 8'hFF, 8'hFF);
    check_frame("blank_0050");

    // All zeros: only digit0 shows, blanked digit3 keeps dp off
    load_val(16'h0000, 4'b1000);
    wait_frame("zero_wait");
    push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF);
    check_frame("blank_0000");

    // Invalid code decodes to a dash
    bus.blank_lz = 1'b0;
    load_val(16'h00A0, 4'b0000);
    wait_frame("invalid_wait");
    push_frame(8'hC0, 8'hBF, 8'hC0, 8'hC0);
    check_frame("invalid_code");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Time-multiplexed driver for the 4-digit common-anode seven-segment display.
- Consumes the packed BCD digits produced by the cascaded up/down digit counters and shows one digit per scan slot.
- Decodes each BCD digit to active-low segments, with optional leading-zero blanking and per-digit decimal points.
- Double-buffers incoming values and applies them only at frame boundaries, so a count change never tears the display mid-frame.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot; legal range 2..65535.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- bcd_in  in  16  packed digits: [3:0] digit0 (least significant) .. [15:12] digit3.
- dp_in  in  4  decimal-point request; bit k applies to digit k, 1 = on.
- load  in  1  capture request for bcd_in/dp_in; level-sampled every clk.
- blank_lz  in  1  1 = leading-zero blanking enabled; sampled live.
- ssd_ctl  out  4  active-low digit enables; bit k selects digit k.
- ssd_seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- frame_done  out  1  one-clk pulse at each frame wrap.

## Operation
- Prescaler `div_cnt`:
  - counts 0..SCAN_DIV-1 and wraps to 0;
  - `tick` = (div_cnt == SCAN_DIV-1).
- Slot register `slot` (2 bits):
  - advances 0→1→2→3→0 on each tick;
  - the edge where slot goes 3→0 is the frame wrap.
- Pending buffer:
  - `load`=1 on a non-wrap edge writes bcd_in/dp_in into `pend_bcd`/`pend_dp` and sets `pend_valid`.
  - A later load before the wrap overwrites the pending value (newest wins).
- Shadow buffer `shad_bcd`/`shad_dp` is the only source for display decode. On the frame-wrap edge:
  - if load=1, bcd_in/dp_in go directly to the shadow;
  - else if pend_valid=1, the pending value goes to the shadow;
  - in both cases pend_valid clears.
- Digit select: ssd_ctl = ~(4'b0001 << slot); exactly one bit is low at all times after reset.
- Segment decode of shad_bcd digit[slot], bits [6:0]:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, dp bit shown as 1);
  - codes A–F decode to dash, g segment only (BF).
- dp: ssd_seg[7] = ~shad_dp[slot].
- Leading-zero blanking, when blank_lz=1:
  - digit k (k = 3, 2, 1) is blanked if it and every higher digit equal 0;
  - digit0 is never blanked;
  - a blanked digit drives ssd_seg = FF (dp also off) while its ssd_ctl bit is still asserted.
- ssd_ctl and ssd_seg are decoded from registered state (slot, shadow) plus blank_lz only; there is no path from bcd_in/load to the outputs.
- frame_done = 1 for exactly the clk cycle following the frame-wrap edge.

## Timing
- Reset values:
  - div_cnt=0, slot=0;
  - shad_bcd=0000, shad_dp=0, pend_valid=0;
  - ssd_ctl=1110, ssd_seg=C0 (digit0 shows "0"), frame_done=0.
- Slot period is SCAN_DIV clks; frame period is 4·SCAN_DIV clks. The first slot after reset lasts SCAN_DIV clks.
- ssd_ctl and ssd_seg change on the same edge as slot, with no skew between them.
- Load-to-display latency:
  - minimum 1 clk (load coincident with the wrap edge);
  - maximum 4·SCAN_DIV clks.
- Asserting rst_n low mid-frame returns all state to reset values immediately (asynchronously); pending data is discarded.
- Deassertion of rst_n is synchronised externally. The first tick occurs SCAN_DIV clks after the first active edge.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset:
  - stimulus: assert rst_n low mid-frame, then release;
  - required: ssd_ctl=1110, ssd_seg=C0, frame_done=0 immediately; the slot-1 transition occurs exactly 4 clks after release.
- Scan order:
  - stimulus: load bcd_in=4321, dp_in=0000, blank_lz=0;
  - required: after the wrap, slots show ctl 1110/F9, 1101/A4, 1011/B0, 0111/99, each for 4 clks, with frame_done pulsing every 16 clks.
- Tearing protection:
  - stimulus: load 1234 during slot 1, then load 5678 during slot 2;
  - required: the old value persists until the wrap, then 5678 is shown; 1234 is never displayed.
- Coincident load at wrap:
  - stimulus: load 0009 on the 3→0 edge while 0005 is pending;
  - required: slot 0 shows 90 in the next cycle.
- Blanking and dp:
  - stimulus: bcd 0050, dp_in=0010, blank_lz=1;
  - required: digits 3 and 2 show FF; digit1 shows 12 (5 with dp on); digit0 shows C0.
  - stimulus: bcd 0000 with blank_lz=1;
  - required: only digit0 shows C0.
- Invalid code:
  - stimulus: bcd_in=00A0;
  - required: digit1 shows BF.
